// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: break-before-make sequencer driving the one-hot select of the glitch-free clock mux.
// Latency: error / same-index response 1 cycle after accept; a real switch completes OFF_CYCLES+ON_CYCLES+1 cycles after accept.
// Backpressure: req_ready is low while a switch is in flight; requests seen while not ready are dropped, never queued.
// Optional: define CLK_SWITCH_IRQ_EN to add a sticky irq output with an irq_clr input.
module clk_switch_ctrl #(
    parameter int NUM_CLOCKS  = 2,
    parameter int SEL_W       = 1,
    parameter int DEFAULT_SEL = 0,
    parameter int OFF_CYCLES  = 8,
    parameter int ON_CYCLES   = 8,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [SEL_W-1:0]      req_sel,
    output logic                  req_ready,
    output logic [NUM_CLOCKS-1:0] clk_select,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  busy,
    output logic                  switch_done,
    output logic                  switch_err
`ifdef CLK_SWITCH_IRQ_EN
    ,
    output logic                  irq,
    input  logic                  irq_clr
`endif
);

    // Parameter sanity: zero-length phases or an undersized index would break the guarantees.
    generate
        if (NUM_CLOCKS < 1) begin : g_bad_num_clocks
            $error("clk_switch_ctrl: NUM_CLOCKS must be at least 1");
        end
        if (SEL_W < 1 || ((SEL_W < 31) && ((1 << SEL_W) < NUM_CLOCKS))) begin : g_bad_sel_w
            $error("clk_switch_ctrl: SEL_W too narrow for NUM_CLOCKS");
        end
        if (DEFAULT_SEL < 0 || DEFAULT_SEL >= NUM_CLOCKS) begin : g_bad_default
            $error("clk_switch_ctrl: DEFAULT_SEL out of range");
        end
        if (CNT_W < 1 || CNT_W > 30) begin : g_bad_cnt_w
            $error("clk_switch_ctrl: CNT_W out of range");
        end
        if (OFF_CYCLES < 1 || OFF_CYCLES > (1 << CNT_W) - 1) begin : g_bad_off
            $error("clk_switch_ctrl: OFF_CYCLES out of range");
        end
        if (ON_CYCLES < 1 || ON_CYCLES > (1 << CNT_W) - 1) begin : g_bad_on
            $error("clk_switch_ctrl: ON_CYCLES out of range");
        end
    endgenerate

    localparam logic [CNT_W-1:0]      OFF_LOAD       = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0]      ON_LOAD        = CNT_W'(ON_CYCLES - 1);
    localparam logic [SEL_W-1:0]      DEFAULT_IDX    = SEL_W'(DEFAULT_SEL);
    localparam logic [NUM_CLOCKS-1:0] DEFAULT_ONEHOT = NUM_CLOCKS'(1) << DEFAULT_SEL;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_MAKE  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [SEL_W-1:0]        pend_sel, pend_sel_nxt;
    logic [NUM_CLOCKS-1:0]   clk_select_nxt;
    logic [SEL_W-1:0]        cur_sel_nxt;
    logic                    req_ready_nxt;
    logic                    busy_nxt;
    logic                    switch_done_nxt;
    logic                    switch_err_nxt;
    logic                    accept;
    logic                    req_oor;

    // Next-state and next-output decode; every output is a flop so the mux sees clean edges.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        pend_sel_nxt    = pend_sel;
        clk_select_nxt  = clk_select;
        cur_sel_nxt     = cur_sel;
        req_ready_nxt   = req_ready;
        busy_nxt        = busy;
        switch_done_nxt = 1'b0;
        switch_err_nxt  = 1'b0;
        accept          = req_valid && req_ready;
        req_oor         = (32'(req_sel) >= 32'(NUM_CLOCKS));

        case (state)
            // DONE behaves like IDLE for acceptance, so a back-to-back request is not lost.
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (req_oor) begin
                        switch_err_nxt = 1'b1;
                    end else if (req_sel == cur_sel) begin
                        switch_done_nxt = 1'b1;
                    end else begin
                        state_nxt      = ST_BREAK;
                        pend_sel_nxt   = req_sel;
                        clk_select_nxt = '0;
                        busy_nxt       = 1'b1;
                        req_ready_nxt  = 1'b0;
                        cnt_nxt        = OFF_LOAD;
                    end
                end
            end
            // All selects off until the old clock's enable pipeline has drained.
            ST_BREAK: begin
                if (cnt == '0) begin
                    state_nxt      = ST_MAKE;
                    clk_select_nxt = NUM_CLOCKS'(1) << pend_sel;
                    cur_sel_nxt    = pend_sel;
                    cnt_nxt        = ON_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            // New select asserted; wait for its enable pipeline to fill before reporting done.
            ST_MAKE: begin
                if (cnt == '0) begin
                    state_nxt       = ST_DONE;
                    switch_done_nxt = 1'b1;
                    busy_nxt        = 1'b0;
                    req_ready_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset lands on the default clock even mid-sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pend_sel    <= DEFAULT_IDX;
            clk_select  <= DEFAULT_ONEHOT;
            cur_sel     <= DEFAULT_IDX;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            switch_done <= 1'b0;
            switch_err  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            pend_sel    <= pend_sel_nxt;
            clk_select  <= clk_select_nxt;
            cur_sel     <= cur_sel_nxt;
            req_ready   <= req_ready_nxt;
            busy        <= busy_nxt;
            switch_done <= switch_done_nxt;
            switch_err  <= switch_err_nxt;
        end
    end

`ifdef CLK_SWITCH_IRQ_EN
    // Sticky interrupt on completion or error; a set coinciding with irq_clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else if (switch_done || switch_err) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb_clk_switch_ctrl: randomized bench with a timeline reference model and an event scoreboard.
// Expected completion/error pulses are queued at issue time; a negedge monitor pops them when the DUT pulses.
// Select, cur_sel, busy and ready are checked every cycle against the model's switch window.
module tb_clk_switch_ctrl;

    localparam int NC  = 3;
    localparam int SW  = 2;
    localparam int DEF = 0;
    localparam int OFF = 5;
    localparam int ON  = 7;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [SW-1:0] req_sel = '0;
    logic          req_ready;
    logic [NC-1:0] clk_select;
    logic [SW-1:0] cur_sel;
    logic          busy;
    logic          switch_done;
    logic          switch_err;
`ifdef CLK_SWITCH_IRQ_EN
    logic          irq;
    logic          irq_clr = 1'b0;
`endif

    clk_switch_ctrl #(
        .NUM_CLOCKS (NC),
        .SEL_W      (SW),
        .DEFAULT_SEL(DEF),
        .OFF_CYCLES (OFF),
        .ON_CYCLES  (ON),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_ready  (req_ready),
        .clk_select (clk_select),
        .cur_sel    (cur_sel),
        .busy       (busy),
        .switch_done(switch_done),
        .switch_err (switch_err)
`ifdef CLK_SWITCH_IRQ_EN
        ,
        .irq        (irq),
        .irq_clr    (irq_clr)
`endif
    );

    always #5 clk = ~clk;

    // Cycle index: outputs seen at negedge n are those produced by posedge n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the most recent switch occupies [m_s, m_s+OFF+ON); before it the old
    // clock is selected, the first OFF cycles are all-off, afterwards the new clock.
    int            m_s   = -1000;
    logic [SW-1:0] m_old = SW'(DEF);
    logic [SW-1:0] m_new = SW'(DEF);

    typedef struct {
        int            t;
        bit            is_err;
        logic [SW-1:0] sel;
    } ev_t;
    ev_t evq[$];

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [NC-1:0] onehot(input logic [SW-1:0] s);
        logic [NC-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    function automatic bit m_busy(input int t);
        return (t >= m_s) && (t < m_s + OFF + ON);
    endfunction

    function automatic logic [NC-1:0] m_sel(input int t);
        if (t < m_s)       return onehot(m_old);
        if (t < m_s + OFF) return '0;
        return onehot(m_new);
    endfunction

    function automatic logic [SW-1:0] m_cur(input int t);
        return (t < m_s + OFF) ? m_old : m_new;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Request presented during cycle t; if the model says ready, the DUT accepts it at the end of t.
    task automatic model_accept(input logic [SW-1:0] s, input int t);
        ev_t e;
        if (32'(s) >= 32'(NC)) begin
            e.t = t + 1; e.is_err = 1'b1; e.sel = m_new;
        end else if (s == m_new) begin
            e.t = t + 1; e.is_err = 1'b0; e.sel = s;
        end else begin
            m_old    = m_new;
            m_new    = s;
            m_s      = t + 1;
            e.t      = t + 1 + OFF + ON;
            e.is_err = 1'b0;
            e.sel    = s;
        end
        evq.push_back(e);
    endtask

    task automatic step(input bit v, input logic [SW-1:0] s);
        @(negedge clk);
        #1;
        req_valid = v;
        req_sel   = s;
        if (v && !m_busy(cyc)) model_accept(s, cyc);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        evq.delete();
        m_s   = -1000;
        m_old = SW'(DEF);
        m_new = SW'(DEF);
        #1;
        chk("rst_clk_select", 32'(clk_select), 32'(onehot(SW'(DEF))));
        chk("rst_cur_sel", 32'(cur_sel), 32'(DEF));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(1));
        chk("rst_switch_done", 32'(switch_done), 32'(0));
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: per-cycle state checks plus scoreboard pops on every done/err pulse.
    always @(negedge clk) begin : mon
        ev_t ev;
        if (!rst) begin
            chk("clk_select", 32'(clk_select), 32'(m_sel(cyc)));
            chk("cur_sel", 32'(cur_sel), 32'(m_cur(cyc)));
            chk("busy", 32'(busy), 32'(m_busy(cyc)));
            chk("req_ready", 32'(req_ready), 32'(!m_busy(cyc)));
            chk("select_popcount_le1", 32'($countones(clk_select) <= 1), 32'(1));
            while (evq.size() > 0 && evq[0].t < cyc) begin
                chk("missing_pulse_due_at", 32'(cyc), 32'(evq[0].t));
                void'(evq.pop_front());
            end
            if (switch_done || switch_err) begin
                chk("done_err_exclusive", 32'(switch_done && switch_err), 32'(0));
                chk("pulse_expected", 32'(evq.size() > 0), 32'(1));
                if (evq.size() > 0) begin
                    ev = evq.pop_front();
                    chk("pulse_cycle", 32'(cyc), 32'(ev.t));
                    chk("pulse_is_err", 32'(switch_err), 32'(ev.is_err));
                    chk("pulse_cur_sel", 32'(cur_sel), 32'(ev.sel));
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;

        // Quiet after reset: default clock held, ready, not busy.
        repeat (20) step(1'b0, '0);

        // Full switch to clock 1.
        step(1'b1, SW'(1));
        repeat (OFF + ON + 3) step(1'b0, '0);

        // Same-index request: immediate done, no busy.
        step(1'b1, SW'(1));
        repeat (3) step(1'b0, '0);

        // Out-of-range index.
        step(1'b1, SW'(3));
        repeat (3) step(1'b0, '0);

        // Switch to clock 2 while hammering requests that must all be ignored.
        step(1'b1, SW'(2));
        repeat (OFF + ON - 1) step(1'b1, SW'($urandom_range(0, 3)));
        repeat (4) step(1'b0, '0);

        // Reset in the middle of BREAK.
        step(1'b1, SW'(1));
        repeat (2) step(1'b0, '0);
        pulse_reset();
        repeat (OFF + ON + 4) step(1'b0, '0);

        // Random traffic, including requests landing in DONE.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 3) == 0), SW'($urandom_range(0, 3)));
        end

        repeat (OFF + ON + 4) step(1'b0, '0);
        chk("outstanding_events", 32'(evq.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
